// File: rtl/lane_gate_arbiter.sv
// lane_gate_arbiter: controller for one shared barrier lane that serves both
// entry and exit traffic. It grants the lane to one side, opens the gate,
// waits for the vehicle to arrive and clear, and then closes the gate. Each
// completed passage produces one pulse for the vehicle counter.
module lane_gate_arbiter #(
   parameter int OPEN_CYCLES  = 4,
   parameter int CLOSE_CYCLES = 4,
   parameter int PASS_TIMEOUT = 16,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic       parking_full,
   input  logic       vehicle_sensor,
   output logic       entry_grant,
   output logic       exit_grant,
   output logic       gate_open_cmd,
   output logic       entry_passed,
   output logic       exit_passed,
   output logic       entry_blocked,
   output logic       timeout_err,
   output logic       busy,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_OPENING    = 3'd1,
      S_WAIT_ENTER = 3'd2,
      S_WAIT_CLEAR = 3'd3,
      S_CLOSING    = 3'd4
   } state_t;

   // Timer reload values. The timer counts down to zero, so a phase that
   // lasts N cycles is loaded with N-1.
   localparam logic [CNT_W-1:0] L_OPEN_LD  = CNT_W'(OPEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_PASS_LD  = CNT_W'(PASS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_CLOSE_LD = CNT_W'(CLOSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_ZERO     = CNT_W'(0);
   localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_timer;
   logic             r_counted;
   logic             r_last_exit;
   logic             r_entry_grant;
   logic             r_exit_grant;
   logic             r_gate;
   logic             r_entry_passed;
   logic             r_exit_passed;
   logic             r_timeout_err;

   logic             w_ent_ok;
   logic             w_ext_ok;
   logic             w_pick_entry;
   logic             w_pick_exit;
   logic             w_timer_zero;

   // A full car park makes entry ineligible. Exits can always be served.
   // When both sides are eligible, the side that was not served last wins.
   assign w_ent_ok     = entry_req & ~parking_full;
   assign w_ext_ok     = exit_req;
   assign w_pick_entry = w_ent_ok & (~w_ext_ok | r_last_exit);
   assign w_pick_exit  = w_ext_ok & ~w_pick_entry;
   assign w_timer_zero = (r_timer == L_ZERO);

   // Lane sequencer: arbitration, gate timing, and the passage/timeout pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_timer        <= L_ZERO;
         r_counted      <= 1'b0;
         r_last_exit    <= 1'b1;
         r_entry_grant  <= 1'b0;
         r_exit_grant   <= 1'b0;
         r_gate         <= 1'b0;
         r_entry_passed <= 1'b0;
         r_exit_passed  <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_entry_passed <= 1'b0;
         r_exit_passed  <= 1'b0;
         r_timeout_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_entry || w_pick_exit) begin
                  r_entry_grant <= w_pick_entry;
                  r_exit_grant  <= w_pick_exit;
                  r_last_exit   <= w_pick_exit;
                  r_gate        <= 1'b1;
                  r_timer       <= L_OPEN_LD;
                  r_counted     <= 1'b0;
                  r_state       <= S_OPENING;
               end else begin
                  r_gate        <= 1'b0;
               end
            end
            S_OPENING: begin
               r_gate <= 1'b1;
               if (w_timer_zero) begin
                  r_timer <= L_PASS_LD;
                  r_state <= S_WAIT_ENTER;
               end else begin
                  r_timer <= r_timer - L_ONE;
               end
            end
            S_WAIT_ENTER: begin
               if (vehicle_sensor) begin
                  r_gate  <= 1'b1;
                  r_state <= S_WAIT_CLEAR;
               end else if (w_timer_zero) begin
                  // Nobody drove through: give up the lane without a count.
                  r_timeout_err <= 1'b1;
                  r_entry_grant <= 1'b0;
                  r_exit_grant  <= 1'b0;
                  r_gate        <= 1'b0;
                  r_timer       <= L_CLOSE_LD;
                  r_state       <= S_CLOSING;
               end else begin
                  r_gate  <= 1'b1;
                  r_timer <= r_timer - L_ONE;
               end
            end
            S_WAIT_CLEAR: begin
               if (!vehicle_sensor) begin
                  r_gate  <= 1'b0;
                  r_timer <= L_CLOSE_LD;
                  r_state <= S_CLOSING;
                  // Only the first clearing of a grant is counted; a safety
                  // reopen during closing returns here with the grant dropped.
                  if (!r_counted) begin
                     r_entry_passed <= r_entry_grant;
                     r_exit_passed  <= r_exit_grant;
                     r_counted      <= 1'b1;
                     r_entry_grant  <= 1'b0;
                     r_exit_grant   <= 1'b0;
                  end else begin
                     r_counted      <= 1'b1;
                  end
               end else begin
                  r_gate <= 1'b1;
               end
            end
            S_CLOSING: begin
               if (vehicle_sensor) begin
                  // Something is under the barrier: reopen at once.
                  r_gate  <= 1'b1;
                  r_state <= S_WAIT_CLEAR;
               end else if (w_timer_zero) begin
                  r_gate  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_gate  <= 1'b0;
                  r_timer <= r_timer - L_ONE;
               end
            end
            default: begin
               r_entry_grant <= 1'b0;
               r_exit_grant  <= 1'b0;
               r_gate        <= 1'b0;
               r_timer       <= L_ZERO;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign entry_grant   = r_entry_grant;
   assign exit_grant    = r_exit_grant;
   assign gate_open_cmd = r_gate;
   assign entry_passed  = r_entry_passed;
   assign exit_passed   = r_exit_passed;
   assign timeout_err   = r_timeout_err;
   assign busy          = (r_state != S_IDLE);
   assign state_dbg     = r_state;
   assign entry_blocked = entry_req & parking_full & (r_state == S_IDLE);

endmodule

// File: tb/tb_lane_gate_arbiter.sv
// Bench for lane_gate_arbiter: directed scenarios with literal expectations,
// plus a phase/age model of the lane that is compared on every clock.
module tb_lane_gate_arbiter;

   localparam int OPEN_CYCLES  = 4;
   localparam int CLOSE_CYCLES = 4;
   localparam int PASS_TIMEOUT = 16;
   localparam int CNT_W        = 8;

   localparam int OWN_NONE = 0;
   localparam int OWN_ENT  = 1;
   localparam int OWN_EXT  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_req, exit_req, parking_full, vehicle_sensor;
   logic       entry_grant, exit_grant, gate_open_cmd;
   logic       entry_passed, exit_passed, entry_blocked, timeout_err, busy;
   logic [2:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ep  = 0;
   int n_xp  = 0;

   // Model: phase (0 idle,1 opening,2 wait enter,3 wait clear,4 closing),
   // cycles completed in that phase, who owns the lane, who won last.
   int m_phase    = 0;
   int m_age      = 0;
   int m_owner    = OWN_NONE;
   int m_prev     = OWN_EXT;
   int m_credited = 0;
   int m_ep       = 0;
   int m_xp       = 0;
   int m_to       = 0;

   always #5 clk = ~clk;

   lane_gate_arbiter #(
      .OPEN_CYCLES (OPEN_CYCLES),
      .CLOSE_CYCLES(CLOSE_CYCLES),
      .PASS_TIMEOUT(PASS_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .parking_full  (parking_full),
      .vehicle_sensor(vehicle_sensor),
      .entry_grant   (entry_grant),
      .exit_grant    (exit_grant),
      .gate_open_cmd (gate_open_cmd),
      .entry_passed  (entry_passed),
      .exit_passed   (exit_passed),
      .entry_blocked (entry_blocked),
      .timeout_err   (timeout_err),
      .busy          (busy),
      .state_dbg     (state_dbg)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_age = 0; m_owner = OWN_NONE; m_prev = OWN_EXT;
      m_credited = 0; m_ep = 0; m_xp = 0; m_to = 0;
   endtask

   // Advance the model by one clock using the inputs seen at that edge.
   task automatic model_step();
      bit ent, ext;
      m_ep = 0; m_xp = 0; m_to = 0;
      ent = entry_req && !parking_full;
      ext = exit_req;
      if (m_phase == 0) begin
         if (ent || ext) begin
            if (ent && ext) m_owner = (m_prev == OWN_EXT) ? OWN_ENT : OWN_EXT;
            else            m_owner = ent ? OWN_ENT : OWN_EXT;
            m_prev = m_owner; m_credited = 0; m_phase = 1; m_age = 0;
         end
      end else if (m_phase == 1) begin
         m_age++;
         if (m_age == OPEN_CYCLES) begin m_phase = 2; m_age = 0; end
      end else if (m_phase == 2) begin
         if (vehicle_sensor) begin
            m_phase = 3; m_age = 0;
         end else begin
            m_age++;
            if (m_age == PASS_TIMEOUT) begin
               m_to = 1; m_owner = OWN_NONE; m_phase = 4; m_age = 0;
            end
         end
      end else if (m_phase == 3) begin
         if (!vehicle_sensor) begin
            if (!m_credited) begin
               m_ep = (m_owner == OWN_ENT); m_xp = (m_owner == OWN_EXT);
               m_credited = 1; m_owner = OWN_NONE;
            end
            m_phase = 4; m_age = 0;
         end
      end else begin
         if (vehicle_sensor) begin
            m_phase = 3; m_age = 0;
         end else begin
            m_age++;
            if (m_age == CLOSE_CYCLES) begin m_phase = 0; m_age = 0; end
         end
      end
   endtask

   task automatic compare_all();
      chk("entry_grant",   entry_grant,   m_owner == OWN_ENT);
      chk("exit_grant",    exit_grant,    m_owner == OWN_EXT);
      chk("gate_open_cmd", gate_open_cmd, m_phase >= 1 && m_phase <= 3);
      chk("entry_passed",  entry_passed,  m_ep);
      chk("exit_passed",   exit_passed,   m_xp);
      chk("timeout_err",   timeout_err,   m_to);
      chk("busy",          busy,          m_phase != 0);
      chk("state_dbg",     state_dbg,     m_phase);
      chk("entry_blocked", entry_blocked, entry_req && parking_full && m_phase == 0);
      chk("grant_mutex",   entry_grant && exit_grant, 0);
   endtask

   // One clock: step the model at the edge, then compare just after it.
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      #1;
      compare_all();
      n_ep += int'(entry_passed);
      n_xp += int'(exit_passed);
   endtask

   task automatic wait_phase(input int p, input string name);
      int n;
      n = 0;
      while (m_phase != p && n < 64) begin
         tick();
         n++;
      end
      if (m_phase != p) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: phase %0d not reached, still %0d", name, p, m_phase);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic sensor_pass();
      wait_phase(2, "pass_wait_enter");
      vehicle_sensor = 1'b1;
      tick();
      tick();
      vehicle_sensor = 1'b0;
      wait_phase(0, "pass_idle");
   endtask

   initial begin
      int ep0, xp0;
      reset = 1'b1;
      entry_req = 1'b0; exit_req = 1'b0; parking_full = 1'b0; vehicle_sensor = 1'b0;
      #2;
      chk("rst_gate",  gate_open_cmd, 0);
      chk("rst_grant", entry_grant | exit_grant, 0);
      chk("rst_state", state_dbg, 0);
      chk("rst_busy",  busy, 0);
      do_reset();

      // Single entry with default timing, cycle numbers after the request edge.
      entry_req = 1'b1;
      tick();
      chk("t1_grant_c1", entry_grant, 1);
      chk("t1_gate_c1",  gate_open_cmd, 1);
      entry_req = 1'b0;
      repeat (4) tick();
      chk("t1_wait_enter_c5", state_dbg, 2);
      repeat (2) tick();
      vehicle_sensor = 1'b1;
      tick();
      tick();
      vehicle_sensor = 1'b0;
      tick();
      chk("t1_passed_c10", entry_passed, 1);
      chk("t1_gate_c10",   gate_open_cmd, 0);
      for (int i = 11; i <= 13; i++) begin
         tick();
         chk("t1_gate_closing", gate_open_cmd, 0);
         chk("t1_single_pulse", entry_passed, 0);
      end
      tick();
      chk("t1_idle_c14", state_dbg, 0);

      // Tie arbitration from a fresh reset: entry, exit, entry.
      do_reset();
      ep0 = n_ep; xp0 = n_xp;
      entry_req = 1'b1; exit_req = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_phase(1, "tie_grant");
         chk("tie_order", {30'd0, entry_grant, exit_grant}, (t % 2 == 0) ? 2 : 1);
         sensor_pass();
      end
      entry_req = 1'b0; exit_req = 1'b0;
      chk("tie_entry_pulses", n_ep - ep0, 2);
      chk("tie_exit_pulses",  n_xp - xp0, 1);

      // Full car park blocks entry; exit still served.
      parking_full = 1'b1; entry_req = 1'b1;
      repeat (3) tick();
      chk("full_blocked", entry_blocked, 1);
      chk("full_not_busy", busy, 0);
      xp0 = n_xp;
      exit_req = 1'b1;
      tick();
      chk("full_exit_grant", exit_grant, 1);
      chk("full_no_entry_grant", entry_grant, 0);
      exit_req = 1'b0;
      sensor_pass();
      chk("full_exit_passed", n_xp - xp0, 1);
      entry_req = 1'b0; parking_full = 1'b0;
      tick();

      // Timeout: no vehicle ever arrives.
      ep0 = n_ep;
      entry_req = 1'b1;
      wait_phase(1, "to_grant");
      entry_req = 1'b0;
      wait_phase(2, "to_wait_enter");
      repeat (PASS_TIMEOUT - 1) tick();
      chk("to_not_early", timeout_err, 0);
      tick();
      chk("to_pulse", timeout_err, 1);
      chk("to_grant_dropped", entry_grant, 0);
      chk("to_gate_closing", gate_open_cmd, 0);
      tick();
      chk("to_single_pulse", timeout_err, 0);
      wait_phase(0, "to_idle");
      chk("to_no_passed", n_ep - ep0, 0);

      // Safety reopen two cycles into closing.
      ep0 = n_ep;
      entry_req = 1'b1;
      wait_phase(1, "sf_grant");
      entry_req = 1'b0;
      wait_phase(2, "sf_wait_enter");
      vehicle_sensor = 1'b1;
      tick();
      tick();
      vehicle_sensor = 1'b0;
      tick();
      chk("sf_closing", state_dbg, 4);
      tick();
      vehicle_sensor = 1'b1;
      tick();
      chk("sf_reopen_gate",  gate_open_cmd, 1);
      chk("sf_reopen_state", state_dbg, 3);
      tick();
      vehicle_sensor = 1'b0;
      tick();
      chk("sf_reclose", state_dbg, 4);
      chk("sf_no_second_pulse", entry_passed, 0);
      for (int i = 0; i < CLOSE_CYCLES - 1; i++) begin
         tick();
         chk("sf_full_close", state_dbg, 4);
      end
      tick();
      chk("sf_idle", state_dbg, 0);
      chk("sf_one_pulse", n_ep - ep0, 1);

      // Reset during WAIT_CLEAR, then a tie must go to entry again.
      ep0 = n_ep;
      entry_req = 1'b1;
      wait_phase(1, "rm_grant");
      entry_req = 1'b0;
      wait_phase(2, "rm_wait_enter");
      vehicle_sensor = 1'b1;
      tick();
      chk("rm_wait_clear", state_dbg, 3);
      #2;
      reset = 1'b1;
      #1;
      chk("rm_gate",  gate_open_cmd, 0);
      chk("rm_grant", entry_grant | exit_grant, 0);
      chk("rm_state", state_dbg, 0);
      chk("rm_pulse", entry_passed | exit_passed, 0);
      tick();
      vehicle_sensor = 1'b0;
      reset = 1'b0;
      entry_req = 1'b1; exit_req = 1'b1;
      tick();
      chk("rm_tie_entry", entry_grant, 1);
      entry_req = 1'b0; exit_req = 1'b0;
      sensor_pass();
      chk("rm_passes", n_ep - ep0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
